// File: rtl/mem_port_arbiter_pkg.sv
// ============================================================================
// mem_arb_pkg: shared types and constants for the fetch/data memory arbiter.
// Revision: 1.0
// ============================================================================
`default_nettype none

package mem_arb_pkg;

  localparam int c_ADDR_W_DEF = 32;
  localparam int c_DATA_W_DEF = 32;
  localparam int c_ALIGN_BITS = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMD  = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } arb_state_t;

  typedef enum logic [0:0] {
    PORT_IF = 1'b0,
    PORT_D  = 1'b1
  } arb_port_t;

  function automatic logic is_misaligned(input logic [c_ALIGN_BITS-1:0] low_bits);
    return (low_bits != '0);
  endfunction

endpackage

`default_nettype wire

// File: rtl/mem_port_arbiter_if.sv
// ============================================================================
// mem_port_arbiter_if: fetch, data and memory-side buses of the arbiter.
// Revision: 1.0
// ============================================================================
`default_nettype none

interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_ack;
  logic [DATA_W-1:0] if_rdata;
  logic              if_err;

  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_ack;
  logic [DATA_W-1:0] d_rdata;
  logic              d_err;

  logic [ADDR_W-1:0] mem_a;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_read;
  logic              mem_write;
  logic [DATA_W-1:0] mem_rdata;

  logic              busy;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    output if_ack, if_rdata, if_err, d_ack, d_rdata, d_err,
           mem_a, mem_wdata, mem_read, mem_write, busy
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    input  if_ack, if_rdata, if_err, d_ack, d_rdata, d_err,
           mem_a, mem_wdata, mem_read, mem_write, busy
  );
endinterface

`default_nettype wire

// File: rtl/mem_port_arbiter_prio.sv
// ============================================================================
// mem_arb_prio: data-over-fetch winner selection with a saturating starve guard.
// Revision: 1.0
// ============================================================================
`default_nettype none

module mem_arb_prio
  import mem_arb_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  wire       clk,
  input  wire       nreset,
  input  wire       if_req_i,
  input  wire       d_req_i,
  input  wire       grant_i,
  output arb_port_t sel_o
);

  localparam int c_CNT_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [c_CNT_W-1:0] c_LIMIT = c_CNT_W'(STARVE_MAX);

  logic [c_CNT_W-1:0] starve_q, starve_d;
  arb_port_t          sel_w;

  always_comb begin
    sel_w = PORT_D;
    if (if_req_i && (!d_req_i || (starve_q == c_LIMIT))) begin
      sel_w = PORT_IF;
    end
  end

  // The guard only counts data grants that actually made fetch wait.
  always_comb begin
    starve_d = starve_q;
    if (!if_req_i) begin
      starve_d = '0;
    end else if (grant_i) begin
      if (sel_w == PORT_IF) begin
        starve_d = '0;
      end else if (starve_q != c_LIMIT) begin
        starve_d = starve_q + c_CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
    end
  end

  assign sel_o = sel_w;

endmodule

`default_nettype wire

// File: rtl/mem_port_arbiter.sv
// ============================================================================
// mem_port_arbiter: shares one single-ported memory between fetch and data ports.
// Revision: 1.0
// ============================================================================
`default_nettype none

module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W     = c_ADDR_W_DEF,
  parameter int DATA_W     = c_DATA_W_DEF,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 4
) (
  input  wire                clk,
  input  wire                nreset,
  mem_port_arbiter_if.slave  bus
);

  localparam int c_WCNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam logic [c_WCNT_W-1:0] c_LAST_WAIT = c_WCNT_W'(MEM_LAT - 1);

  arb_state_t          state_q, state_d;
  arb_port_t           port_q, port_d;
  logic                we_q, we_d;
  logic                err_q, err_d;
  logic [ADDR_W-1:0]   mem_a_q, mem_a_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic [c_WCNT_W-1:0] wcnt_q, wcnt_d;
  logic [DATA_W-1:0]   if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0]   d_rdata_q, d_rdata_d;

  logic                grant_w;
  arb_port_t           sel_w;
  logic [DATA_W-1:0]   rdata_w;

  mem_arb_prio #(
    .STARVE_MAX (STARVE_MAX)
  ) u_prio (
    .clk      (clk),
    .nreset   (nreset),
    .if_req_i (bus.if_req),
    .d_req_i  (bus.d_req),
    .grant_i  (grant_w),
    .sel_o    (sel_w)
  );

  always_comb begin
    state_d     = state_q;
    port_d      = port_q;
    we_d        = we_q;
    err_d       = err_q;
    mem_a_d     = mem_a_q;
    mem_wdata_d = mem_wdata_q;
    wcnt_d      = wcnt_q;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;
    grant_w     = 1'b0;
    rdata_w     = '0;

    case (state_q)
      IDLE: begin
        if (bus.if_req || bus.d_req) begin
          grant_w = 1'b1;
          port_d  = sel_w;
          if (sel_w == PORT_IF) begin
            mem_a_d     = bus.if_addr;
            mem_wdata_d = '0;
            we_d        = 1'b0;
          end else begin
            mem_a_d     = bus.d_addr;
            mem_wdata_d = bus.d_wdata;
            we_d        = bus.d_we;
          end
          err_d   = is_misaligned(mem_a_d[c_ALIGN_BITS-1:0]);
          state_d = CMD;
        end
      end
      CMD: begin
        wcnt_d  = '0;
        state_d = WAIT;
      end
      WAIT: begin
        if (wcnt_q == c_LAST_WAIT) begin
          // Stores and errored accesses report zero data.
          if (!we_q && !err_q) begin
            rdata_w = bus.mem_rdata;
          end
          if (port_q == PORT_IF) begin
            if_rdata_d = rdata_w;
          end else begin
            d_rdata_d = rdata_w;
          end
          state_d = RESP;
        end else begin
          wcnt_d = wcnt_q + c_WCNT_W'(1);
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q     <= IDLE;
      port_q      <= PORT_IF;
      we_q        <= 1'b0;
      err_q       <= 1'b0;
      mem_a_q     <= '0;
      mem_wdata_q <= '0;
      wcnt_q      <= '0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
    end else begin
      state_q     <= state_d;
      port_q      <= port_d;
      we_q        <= we_d;
      err_q       <= err_d;
      mem_a_q     <= mem_a_d;
      mem_wdata_q <= mem_wdata_d;
      wcnt_q      <= wcnt_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
    end
  end

  assign bus.mem_a     = mem_a_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.mem_read  = (state_q == CMD) && !we_q && !err_q;
  assign bus.mem_write = (state_q == CMD) && we_q && !err_q;

  assign bus.if_ack    = (state_q == RESP) && (port_q == PORT_IF);
  assign bus.d_ack     = (state_q == RESP) && (port_q == PORT_D);
  assign bus.if_err    = bus.if_ack && err_q;
  assign bus.d_err     = bus.d_ack && err_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.d_rdata   = d_rdata_q;
  assign bus.busy      = (state_q != IDLE);

endmodule

`default_nettype wire
